// File: rtl/alu_op_issue_pkg.sv
// Shared ALU op codes, opcode/funct constants and the issue bundle layout.
package alu_op_issue_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;
  localparam logic [3:0] ALU_SBT  = 4'b1101;
  localparam logic [3:0] ALU_SLA  = 4'b1110;
  localparam logic [3:0] ALU_LLI  = 4'b1111;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LLI     = 6'b011101;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SLA  = 6'b000101;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SBT  = 6'b101110;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  wdest;
  } alu_bundle_t;

  localparam int BUNDLE_W = $bits(alu_bundle_t);

endpackage

// File: rtl/alu_op_fifo.sv
// Generic synchronous FIFO with flush. When empty, rdata shows the last
// popped word so the ALU side sees stable data between transactions.
module alu_op_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? last : mem[rd_ptr];

  // Pointers and occupancy; flush empties the queue like reset does.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; never read while its slot is invalid, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Holds the most recently popped word for display while empty.
  always_ff @(posedge clk) begin
    if (reset)       last <= '0;
    else if (do_pop) last <= mem[rd_ptr];
  end

endmodule

// File: rtl/alu_op_issue.sv
// Decodes instruction words into ALU control bundles and queues them for
// the ALU stage. Illegal and dest-zero instructions are consumed but dropped.
module alu_op_issue
  import alu_op_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_control,
  output logic [31:0]      out_alu_src1,
  output logic [31:0]      out_alu_src2,
  output logic [4:0]       out_wdest,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [4:0]  rt;
  logic [4:0]  rd;

  alu_bundle_t dec;
  alu_bundle_t head;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  assign op  = in_inst[31:26];
  assign rt  = in_inst[20:16];
  assign rd  = in_inst[15:11];
  assign sh  = in_inst[10:6];
  assign fn  = in_inst[5:0];
  assign imm = in_inst[15:0];

  // Instruction decode: R-type writes rd, I-type writes rt.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (op)
      OP_SPECIAL: begin
        legal     = 1'b1;
        dec.src1  = in_rs_val;
        dec.src2  = in_rt_val;
        dec.wdest = rd;
        case (fn)
          FN_ADDU: dec.ctrl = ALU_ADD;
          FN_SUBU: dec.ctrl = ALU_SUB;
          FN_SLT:  dec.ctrl = ALU_SLT;
          FN_SLTU: dec.ctrl = ALU_SLTU;
          FN_AND:  dec.ctrl = ALU_AND;
          FN_NOR:  dec.ctrl = ALU_NOR;
          FN_OR:   dec.ctrl = ALU_OR;
          FN_XOR:  dec.ctrl = ALU_XOR;
          FN_SLLV: dec.ctrl = ALU_SLL;
          FN_SBT:  dec.ctrl = ALU_SBT;
          FN_SLL: begin
            dec.ctrl = ALU_SLL;
            dec.src1 = {27'b0, sh};
          end
          FN_SRL: begin
            dec.ctrl = ALU_SRL;
            dec.src1 = {27'b0, sh};
          end
          FN_SRA: begin
            dec.ctrl = ALU_SRA;
            dec.src1 = {27'b0, sh};
          end
          FN_SLA: begin
            dec.ctrl = ALU_SLA;
            dec.src1 = {27'b0, sh};
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        legal     = 1'b1;
        dec.ctrl  = ALU_ADD;
        dec.src1  = in_rs_val;
        dec.src2  = {{16{imm[15]}}, imm};
        dec.wdest = rt;
      end
      OP_LUI: begin
        legal     = 1'b1;
        dec.ctrl  = ALU_LUI;
        dec.src2  = {16'b0, imm};
        dec.wdest = rt;
      end
      OP_LLI: begin
        legal     = 1'b1;
        dec.ctrl  = ALU_LLI;
        dec.src2  = {16'b0, imm};
        dec.wdest = rt;
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal && (dec.wdest != 5'd0);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !flush;

  alu_op_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(BUNDLE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (dec),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_alu_control = head.ctrl;
  assign out_alu_src1    = head.src1;
  assign out_alu_src2    = head.src2;
  assign out_wdest       = head.wdest;

  // Saturating debug counters and the one-cycle illegal indicator.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt     <= '0;
      illegal_cnt   <= '0;
      illegal_pulse <= 1'b0;
    end else begin
      illegal_pulse <= accept && !legal;
      if (push && (issue_cnt != '1))
        issue_cnt <= issue_cnt + CNT_W'(1);
      if (accept && !legal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule
